dt_tick_scheduler: RTL
======================

DT_TICK_SCHEDULER -- requirements
Module: dt_tick_scheduler

Interface
REQ-001 The block SHALL have parameter POINTS_PER_LINE_P, default 360, meaning scan points per line (>=2).
REQ-002 The block SHALL have parameter LINES_PER_FRAME_P, default 240, meaning lines per frame (>=1).
REQ-003 The block SHALL have parameter NUMBER_OF_FRAMES_P, default 5, meaning frames per run (>=1).
REQ-004 The block SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1; reset is asynchronous and active-high.
REQ-006 The block SHALL have port enable_i, input, 1, the run enable.
REQ-007 The block SHALL have port dt_ticks_valid_i, input, 1, the upstream tick-interval valid.
REQ-008 The block SHALL have port dt_ticks_i, input, 16, the tick interval in clk_i cycles.
REQ-009 The block SHALL have port dt_ticks_ready_o, output, 1, meaning the block can accept an interval.
REQ-010 The block SHALL have port pixel_pulse_o, output, 1, a one-cycle strobe per scan point.
REQ-011 The block SHALL have port line_end_o, output, 1, asserted with the last pixel pulse of each line.
REQ-012 The block SHALL have port frame_end_o, output, 1, asserted with the last pixel pulse of each frame.
REQ-013 The block SHALL have ports point_idx_o, line_idx_o and frame_idx_o, outputs, 16/16/8, giving the current point, line and frame index.
REQ-014 The block SHALL have ports busy_o, done_o and underrun_o, outputs, 1 each.

Function
REQ-015 An input transfer SHALL occur on a cycle with dt_ticks_valid_i and dt_ticks_ready_o both high; dt_ticks_ready_o is high exactly when the buffer is not full.
REQ-016 The FSM SHALL have states IDLE, COUNT and DONE; busy_o is high in COUNT and done_o is high in DONE.
REQ-017 IDLE: when enable_i is high and the buffer is non-empty, the FSM SHALL pop one entry, load the down-counter with max(dt,1) (dt=0 treated as 1), and go to COUNT.
REQ-018 COUNT with counter>1: the block SHALL decrement the counter.
REQ-019 COUNT with counter==1: the block SHALL assert pixel_pulse_o for that cycle, so the pulse falls exactly dt cycles after the pop cycle.
REQ-020 On that pulse, if it is the final point of the final line of the final frame, the FSM SHALL go to DONE.
REQ-021 Otherwise, if the buffer is non-empty, the FSM SHALL pop and reload in the same cycle, staying in COUNT with no gap cycle.
REQ-022 Otherwise (buffer empty), the block SHALL set underrun_o (sticky until reset) and return to IDLE, resuming on the next available entry.
REQ-023 Indices SHALL advance on each pulse: point_idx wraps from POINTS_PER_LINE_P-1 to 0 with line_end_o; line_idx wraps from LINES_PER_FRAME_P-1 to 0 with frame_end_o; frame_idx then increments.
REQ-024 The indices SHALL update the cycle after the pulse, so the pulse cycle shows the index of the point being emitted.
REQ-025 When enable_i is low in COUNT, the block SHALL abort to IDLE, clearing the counter and all indices; buffered entries are retained and no pulse is emitted.
REQ-026 DONE SHALL hold until enable_i is low, then go to IDLE with indices cleared; in DONE no entries are popped, though the buffer still accepts pushes until full.
REQ-027 Pushing into an empty buffer SHALL not fall through: the entry becomes poppable on the next cycle.
REQ-028 A simultaneous push and pop on a non-empty, non-full buffer SHALL leave the occupancy unchanged.

Reset
REQ-029 While rst_i is high, the block SHALL force: state IDLE; buffer empty; counter 0; all indices 0; pixel_pulse_o, line_end_o, frame_end_o, busy_o, done_o and underrun_o at 0; dt_ticks_ready_o at 0.
REQ-030 dt_ticks_ready_o SHALL rise on the first clock edge after rst_i is released.
REQ-031 Asserting rst_i mid-operation SHALL discard all buffered entries immediately.

Configuration
REQ-032 With macro DT_TICK_SCHEDULER_FIFO_EN defined, the input buffer SHALL be a 4-entry FIFO.
REQ-033 Without DT_TICK_SCHEDULER_FIFO_EN, the input buffer SHALL be a single-entry register, with dt_ticks_ready_o high only when that register is empty.
REQ-034 Every other requirement SHALL hold in both builds.

Verification
REQ-035 Scenario: POINTS=4, LINES=2, FRAMES=1; stream 8 entries of dt=3, always valid -> 8 pulses spaced 3 cycles apart; line_end_o on pulses 4 and 8; frame_end_o on pulse 8; done_o is then high; underrun_o stays 0.
REQ-036 Scenario: dt sequence 0,1,5 -> pulses at pop+1, then +1 cycle, then +5 cycles.
REQ-037 Scenario: valid deasserted for 10 cycles after the 2nd entry, dt=2 -> underrun_o latches 1 at the 2nd pulse; the 3rd pulse occurs 2 cycles after the next pop.
REQ-038 Scenario: enable_i dropped at counter=2 during point 5 -> no pulse, busy_o is 0 the next cycle, point_idx_o reads 0, and buffered entries remain.
REQ-039 Scenario: FIFO build, hold upstream valid while the FSM is in IDLE with enable_i low -> dt_ticks_ready_o falls after 4 accepted entries and rises the cycle after the first pop.
REQ-040 Scenario: rst_i asserted mid-line -> all outputs read 0 asynchronously, and the first pulse after restart has point_idx_o equal to 0.

Source files
------------

// File: rtl/dt_tick_scheduler.sv
// Scan-point tick scheduler: pops tick intervals from an input buffer and emits a
// pixel strobe per interval with point/line/frame tracking. DT_TICK_SCHEDULER_FIFO_EN selects a 4-entry FIFO.
module dt_tick_scheduler #(
  parameter int POINTS_PER_LINE_P  = 360,
  parameter int LINES_PER_FRAME_P  = 240,
  parameter int NUMBER_OF_FRAMES_P = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        dt_ticks_valid_i,
  input  logic [15:0] dt_ticks_i,
  output logic        dt_ticks_ready_o,
  output logic        pixel_pulse_o,
  output logic        line_end_o,
  output logic        frame_end_o,
  output logic [15:0] point_idx_o,
  output logic [15:0] line_idx_o,
  output logic [7:0]  frame_idx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        underrun_o
);

`ifdef DT_TICK_SCHEDULER_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  logic [DEPTH-1:0][15:0] mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count, count_nxt;
  logic                   ready_q, push, pop, empty;
  logic [15:0]            head, load;

  state_t      state;
  logic [15:0] cnt;
  logic        pulse, last_pt, last_ln, final_pt;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign load      = (head == 16'd0) ? 16'd1 : head;
  assign push      = dt_ticks_valid_i && ready_q;
  assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign last_pt  = (point_idx_o == 16'(POINTS_PER_LINE_P - 1));
  assign last_ln  = (line_idx_o == 16'(LINES_PER_FRAME_P - 1));
  assign final_pt = last_pt && last_ln && (frame_idx_o == 8'(NUMBER_OF_FRAMES_P - 1));
  assign pulse    = (state == COUNT) && enable_i && (cnt <= 16'd1);
  // Pop from IDLE to start counting, or back-to-back on a non-final pulse.
  assign pop      = !empty && enable_i && ((state == IDLE) || (pulse && !final_pt));

  assign dt_ticks_ready_o = ready_q;
  assign pixel_pulse_o    = pulse;
  assign line_end_o       = pulse && last_pt;
  assign frame_end_o      = pulse && last_pt && last_ln;
  assign busy_o           = (state == COUNT);
  assign done_o           = (state == DONE);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= dt_ticks_i;
  end

  // Ready is registered from next occupancy so it stays low throughout reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      count   <= count_nxt;
      ready_q <= (count_nxt != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      point_idx_o <= '0;
      line_idx_o  <= '0;
      frame_idx_o <= '0;
      underrun_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            cnt   <= load;
            state <= COUNT;
          end
        end
        COUNT: begin
          if (!enable_i) begin
            state       <= IDLE;
            cnt         <= '0;
            point_idx_o <= '0;
            line_idx_o  <= '0;
            frame_idx_o <= '0;
          end else if (cnt > 16'd1) begin
            cnt <= cnt - 16'd1;
          end else begin
            if (last_pt) begin
              point_idx_o <= '0;
              if (last_ln) begin
                line_idx_o  <= '0;
                frame_idx_o <= frame_idx_o + 8'd1;
              end else begin
                line_idx_o <= line_idx_o + 16'd1;
              end
            end else begin
              point_idx_o <= point_idx_o + 16'd1;
            end
            if (final_pt) begin
              state <= DONE;
              cnt   <= '0;
            end else if (!empty) begin
              cnt <= load;
            end else begin
              underrun_o <= 1'b1;
              state      <= IDLE;
              cnt        <= '0;
            end
          end
        end
        DONE: begin
          if (!enable_i) begin
            state       <= IDLE;
            point_idx_o <= '0;
            line_idx_o  <= '0;
            frame_idx_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
